// File: rtl/fifo_async_pkg.sv
// Shared helpers for the asynchronous FIFO pointer controllers:
// pointer width and gray/binary conversion functions.
package fifo_async_pkg;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_async_rptr_ctrl_if.sv
// Bundle of the read-side controller's request, status and pointer signals.
// master = the environment driving requests, slave = the controller.
interface fifo_async_rptr_ctrl_if
  import fifo_async_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
);
  localparam int PW = ptr_w(ADDR_WIDTH);

  logic                  read_in;
  logic                  clr_err_in;
  logic [PW-1:0]         ae_thresh_in;
  logic [PW-1:0]         wptr_g_async_in;
  logic [ADDR_WIDTH-1:0] raddr_out;
  logic                  ren_out;
  logic [PW-1:0]         rptr_b_out;
  logic [PW-1:0]         rptr_g_out;
  logic                  empty_out;
  logic                  almost_empty_out;
  logic [PW-1:0]         rlevel_out;
  logic                  underflow_out;

  modport master (
    output read_in, clr_err_in, ae_thresh_in, wptr_g_async_in,
    input  raddr_out, ren_out, rptr_b_out, rptr_g_out,
           empty_out, almost_empty_out, rlevel_out, underflow_out
  );

  modport slave (
    input  read_in, clr_err_in, ae_thresh_in, wptr_g_async_in,
    output raddr_out, ren_out, rptr_b_out, rptr_g_out,
           empty_out, almost_empty_out, rlevel_out, underflow_out
  );

endinterface

// File: rtl/fifo_sync_chain.sv
// Multi-flop synchroniser for a gray-coded pointer crossing clock domains.
// Only one bit changes per pointer step, so each stage captures either the
// old or the new code, never a mix. STAGES must be at least 2.
module fifo_sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the asynchronous input down the chain every clock.
  // NOTE: the chain is a small array of flops, but unlike a RAM it must be
  // reset so no stale pointer from before reset can leak into the flags.
  // NOTE: non-blocking assignments make every stage sample the previous
  // stage's old value, which is what gives the chain its depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of
// all gray bits at and above it.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/fifo_async_rptr_ctrl.sv
// Read-side pointer and status controller of the asynchronous FIFO.
// Synchronises the write pointer, advances the read pointer on accepted
// pops and registers fill level, empty, almost-empty and sticky underflow.
module fifo_async_rptr_ctrl
  import fifo_async_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  nrst_in,
  fifo_async_rptr_ctrl_if.slave bus
);

  localparam int PW = ptr_w(ADDR_WIDTH);

  logic [PW-1:0] wsync_g;
  logic [PW-1:0] wsync_b;
  logic [PW-1:0] rptr_b_q;
  logic [PW-1:0] rptr_g_q;
  logic [PW-1:0] rlevel_q;
  logic [PW-1:0] rptr_b_next;
  logic [PW-1:0] rptr_g_next;
  logic [PW-1:0] level_next;
  logic          empty_q;
  logic          almost_empty_q;
  logic          underflow_q;
  logic          pop;

  fifo_sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (clk_in),
    .rst_n (nrst_in),
    .d     (bus.wptr_g_async_in),
    .q     (wsync_g)
  );

  gray2bin #(
    .WIDTH (PW)
  ) u_wptr_g2b (
    .gray (wsync_g),
    .bin  (wsync_b)
  );

  // Next read pointer and fill level; PW-bit arithmetic wraps naturally.
  // NOTE: every signal here is assigned on the single straight-line path,
  // so no latch can be inferred even without explicit defaults.
  always_comb begin
    pop         = bus.read_in & ~empty_q;
    rptr_b_next = rptr_b_q + PW'(pop);
    rptr_g_next = PW'(bin2gray(32'(rptr_b_next)));
    level_next  = wsync_b - rptr_b_next;
  end

  // Register pointers and status flags; flags look at the post-pop pointer
  // so the emptying pop raises empty_out on the same edge.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      rptr_b_q       <= '0;
      rptr_g_q       <= '0;
      rlevel_q       <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      rptr_b_q       <= rptr_b_next;
      rptr_g_q       <= rptr_g_next;
      rlevel_q       <= level_next;
      empty_q        <= (wsync_b == rptr_b_next);
      almost_empty_q <= (level_next <= bus.ae_thresh_in);
      // A new underflow outranks a clear in the same cycle.
      underflow_q    <= (underflow_q & ~bus.clr_err_in) | (bus.read_in & empty_q);
    end
  end

  assign bus.raddr_out        = rptr_b_q[ADDR_WIDTH-1:0];
  assign bus.ren_out          = pop;
  assign bus.rptr_b_out       = rptr_b_q;
  assign bus.rptr_g_out       = rptr_g_q;
  assign bus.rlevel_out       = rlevel_q;
  assign bus.empty_out        = empty_q;
  assign bus.almost_empty_out = almost_empty_q;
  assign bus.underflow_out    = underflow_q;

endmodule

// File: tb/tb_fifo_async_rptr_ctrl.sv
// Self-checking bench for fifo_async_rptr_ctrl: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_fifo_async_rptr_ctrl;

  localparam int AW    = 3;
  localparam int SS    = 2;
  localparam int PW    = AW + 1;
  localparam int MOD   = 1 << PW;
  localparam int DEPTH = 1 << AW;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   w_bin = 0;

  fifo_async_rptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_async_rptr_ctrl #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_in  (clk),
    .nrst_in (nrst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // The write side is modelled as a binary count presented in gray code.
  assign bus.wptr_g_async_in = PW'(w_bin ^ (w_bin >> 1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist holds the write pointer seen at the last SS edges (oldest first);
  // the oldest entry is what the flags registered on this edge can know.
  int m_rptr, m_level, m_ws;
  bit m_empty, m_ae, m_under, m_pop;
  int hist[$];

  function automatic void m_reset();
    m_rptr  = 0;
    m_level = 0;
    m_empty = 1;
    m_ae    = 1;
    m_under = 0;
    hist    = {};
    repeat (SS) hist.push_back(0);
  endfunction

  initial m_reset();

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_reset();
    end else begin
      m_ws    = hist.pop_front();
      m_pop   = bus.read_in && !m_empty;
      m_under = (m_under && !bus.clr_err_in) || (bus.read_in && m_empty);
      m_rptr  = (m_rptr + int'(m_pop)) % MOD;
      m_level = (m_ws - m_rptr + MOD) % MOD;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= int'(bus.ae_thresh_in));
      hist.push_back(w_bin % MOD);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #2;
    if (nrst) begin
      check("m_rptr_b", 32'(bus.rptr_b_out), 32'(m_rptr));
      check("m_rptr_g", 32'(bus.rptr_g_out), 32'(m_rptr ^ (m_rptr >> 1)));
      check("m_raddr", 32'(bus.raddr_out), 32'(m_rptr % DEPTH));
      check("m_level", 32'(bus.rlevel_out), 32'(m_level));
      check("m_empty", 32'(bus.empty_out), 32'(m_empty));
      check("m_aempty", 32'(bus.almost_empty_out), 32'(m_ae));
      check("m_underflow", 32'(bus.underflow_out), 32'(m_under));
      check("m_ren", 32'(bus.ren_out), 32'(bus.read_in && !m_empty));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge: apply inputs, let one rising edge pass.
  task automatic tick(input bit rd, input bit clr, input bit winc);
    bus.read_in    = rd;
    bus.clr_err_in = clr;
    if (winc) w_bin = (w_bin + 1) % MOD;
    @(negedge clk);
  endtask

  // Asynchronous reset; outputs checked before any clock edge arrives.
  task automatic do_reset(input string tag);
    nrst           = 1'b0;
    w_bin          = 0;
    bus.read_in    = 1'b0;
    bus.clr_err_in = 1'b0;
    #1;
    check({tag, "_rptr_b"}, 32'(bus.rptr_b_out), 0);
    check({tag, "_rptr_g"}, 32'(bus.rptr_g_out), 0);
    check({tag, "_raddr"}, 32'(bus.raddr_out), 0);
    check({tag, "_level"}, 32'(bus.rlevel_out), 0);
    check({tag, "_empty"}, 32'(bus.empty_out), 1);
    check({tag, "_aempty"}, 32'(bus.almost_empty_out), 1);
    check({tag, "_underflow"}, 32'(bus.underflow_out), 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  int wr_pct;
  int occ;

  initial begin
    bus.read_in      = 1'b0;
    bus.clr_err_in   = 1'b0;
    bus.ae_thresh_in = PW'(2);
    #1;
    do_reset("rst0");

    // Visibility: one written word appears on the third edge.
    tick(0, 0, 1);
    check("vis_e1_empty", 32'(bus.empty_out), 1);
    tick(0, 0, 0);
    check("vis_e2_empty", 32'(bus.empty_out), 1);
    tick(0, 0, 0);
    check("vis_e3_empty", 32'(bus.empty_out), 0);
    check("vis_e3_level", 32'(bus.rlevel_out), 1);
    #2;
    do_reset("rst1");

    // Full drain of a completely full FIFO.
    repeat (8) tick(0, 0, 1);
    repeat (3) tick(0, 0, 0);
    check("full_level", 32'(bus.rlevel_out), 8);
    check("full_empty", 32'(bus.empty_out), 0);
    for (int k = 1; k <= 8; k++) begin
      bus.read_in = 1'b1;
      #1;
      check("drain_ren", 32'(bus.ren_out), 1);
      @(negedge clk);
      check("drain_raddr", 32'(bus.raddr_out), 32'(k % 8));
    end
    check("drain_empty", 32'(bus.empty_out), 1);
    check("drain_rptr_g", 32'(bus.rptr_g_out), 32'b1100);
    check("drain_level", 32'(bus.rlevel_out), 0);
    tick(0, 0, 0);

    // Almost-empty with threshold 2 starting from level 4.
    repeat (4) tick(0, 0, 1);
    repeat (3) tick(0, 0, 0);
    check("ae_l4_level", 32'(bus.rlevel_out), 4);
    check("ae_l4_flag", 32'(bus.almost_empty_out), 0);
    tick(1, 0, 0);
    check("ae_l3_level", 32'(bus.rlevel_out), 3);
    check("ae_l3_flag", 32'(bus.almost_empty_out), 0);
    tick(1, 0, 0);
    check("ae_l2_level", 32'(bus.rlevel_out), 2);
    check("ae_l2_flag", 32'(bus.almost_empty_out), 1);

    // Underflow: set, set-beats-clear, clear.
    tick(1, 0, 0);
    check("uf_l1_level", 32'(bus.rlevel_out), 1);
    tick(1, 0, 0);
    check("uf_empty", 32'(bus.empty_out), 1);
    check("uf_rptr_before", 32'(bus.rptr_b_out), 12);
    check("uf_none_yet", 32'(bus.underflow_out), 0);
    tick(1, 0, 0);
    check("uf_rptr_held", 32'(bus.rptr_b_out), 12);
    check("uf_set", 32'(bus.underflow_out), 1);
    check("uf_ren_low", 32'(bus.ren_out), 0);
    tick(1, 1, 0);
    check("uf_set_wins", 32'(bus.underflow_out), 1);
    check("uf_rptr_held2", 32'(bus.rptr_b_out), 12);
    tick(0, 1, 0);
    check("uf_cleared", 32'(bus.underflow_out), 0);
    tick(0, 0, 0);

    // Wrap: pointer 15 -> 0, gray 1000 -> 0000.
    repeat (3) tick(0, 0, 1);
    repeat (3) tick(0, 0, 0);
    repeat (3) tick(1, 0, 0);
    check("wrap_rptr_b15", 32'(bus.rptr_b_out), 15);
    check("wrap_rptr_g15", 32'(bus.rptr_g_out), 32'b1000);
    repeat (3) tick(0, 0, 1);
    repeat (3) tick(0, 0, 0);
    check("wrap_level3", 32'(bus.rlevel_out), 3);
    tick(1, 0, 0);
    check("wrap_rptr_b0", 32'(bus.rptr_b_out), 0);
    check("wrap_rptr_g0", 32'(bus.rptr_g_out), 0);
    check("wrap_level2", 32'(bus.rlevel_out), 2);
    tick(0, 0, 0);

    // Mid-stream reset with the pointer at 5 and data still present.
    repeat (3) tick(0, 0, 1);
    repeat (3) tick(0, 0, 0);
    repeat (5) tick(1, 0, 0);
    repeat (2) tick(0, 0, 1);
    repeat (3) tick(0, 0, 0);
    check("mid_rptr_b5", 32'(bus.rptr_b_out), 5);
    check("mid_level2", 32'(bus.rlevel_out), 2);
    #2;
    do_reset("rst_mid");

    // Randomized traffic against the model.
    wr_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) wr_pct = 20 + 30 * int'($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) bus.ae_thresh_in = PW'($urandom_range(0, DEPTH));
      if ($urandom_range(0, 999) == 0) begin
        #2;
        do_reset("rst_rand");
      end
      occ = (w_bin - m_rptr + MOD) % MOD;
      tick(bit'($urandom_range(0, 99) < 100 - wr_pct),
           bit'($urandom_range(0, 15) == 0),
           bit'(occ < DEPTH && $urandom_range(0, 99) < wr_pct));
    end
    repeat (4) tick(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
